// File: rtl/ape_sched_pkg.sv
// ape_sched_pkg
// Shared definitions for the APE output-buffer scheduler:
//   - state_e       : scheduler FSM states
//   - FILTER_CNT_W  : default width of the filter count / filter index
//   - STEP_CNT_W    : default width of the accumulate-step count / step index
package ape_sched_pkg;

    localparam int FILTER_CNT_W = 8;
    localparam int STEP_CNT_W   = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_BIAS = 3'd1,
        ACCUM     = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/ape_sched_counter.sv
// ape_sched_counter
// Loadable up-counter with a terminal-count flag.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   load         : load load_val (takes priority over inc)
//   load_val     : value to load
//   inc          : increment by one
//   term_val     : terminal value compared against the current count
//   count        : current count
//   tc           : count == term_val
module ape_sched_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == term_val);

endmodule

// File: rtl/ape_buffer_scheduler.sv
// ape_buffer_scheduler
// Sequences one APE output-buffer tile per filter: bias preload (1 cycle),
// num_steps accumulate steps, then drain of the finished tile to writeback.
// Optional feature macro: APE_SCHED_PERF_EN (stall-cycle counter on
// perf_stall_cycles; tied to 0 when undefined).
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   start, abort            : layer start (IDLE only), synchronous abort
//   num_filters, num_steps  : layer geometry, latched on accepted start
//   step_valid / step_req   : adder result handshake (ACCUM)
//   buf_w_enable            : bias-load strobe (LOAD_BIAS)
//   buf_enable              : accumulate strobe (ACCUM & step_valid)
//   bias_idx, filter_idx    : current filter (bias address == filter index)
//   step_idx                : current accumulate step
//   out_valid / out_ready   : tile handshake to writeback (DRAIN)
//   busy, done              : state != IDLE, one-cycle completion pulse
//   perf_stall_cycles       : stall counter
//   state_dbg               : current FSM state
// Handshakes: a transfer happens on a cycle where both valid and ready are 1;
// the valid side holds its data stable until that cycle.
module ape_buffer_scheduler #(
    parameter int FILTER_CNT_W = ape_sched_pkg::FILTER_CNT_W,
    parameter int STEP_CNT_W   = ape_sched_pkg::STEP_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [FILTER_CNT_W-1:0] num_filters,
    input  logic [STEP_CNT_W-1:0]   num_steps,
    input  logic                    step_valid,
    output logic                    step_req,
    output logic                    buf_w_enable,
    output logic                    buf_enable,
    output logic [FILTER_CNT_W-1:0] bias_idx,
    output logic [FILTER_CNT_W-1:0] filter_idx,
    output logic [STEP_CNT_W-1:0]   step_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             perf_stall_cycles,
    output logic [2:0]              state_dbg
);

    import ape_sched_pkg::*;

    state_e                  state_q, state_d;
    logic [FILTER_CNT_W-1:0] num_filters_q, num_filters_d;
    logic [STEP_CNT_W-1:0]   num_steps_q, num_steps_d;

    logic f_load, f_inc, f_tc;
    logic s_load, s_inc, s_tc;

    // Terminal compares use count-1 so the index never wraps past the last value.
    ape_sched_counter #(.W(FILTER_CNT_W)) u_filter_cnt (
        .clk      (clock),
        .rst_n    (reset_n),
        .load     (f_load),
        .load_val ('0),
        .inc      (f_inc),
        .term_val (num_filters_q - 1'b1),
        .count    (filter_idx),
        .tc       (f_tc)
    );

    ape_sched_counter #(.W(STEP_CNT_W)) u_step_cnt (
        .clk      (clock),
        .rst_n    (reset_n),
        .load     (s_load),
        .load_val ('0),
        .inc      (s_inc),
        .term_val (num_steps_q - 1'b1),
        .count    (step_idx),
        .tc       (s_tc)
    );

    always_comb begin
        state_d       = state_q;
        num_filters_d = num_filters_q;
        num_steps_d   = num_steps_q;
        f_load        = 1'b0;
        f_inc         = 1'b0;
        s_load        = 1'b0;
        s_inc         = 1'b0;
        if (abort) begin
            // Abort overrides every transition, including a same-cycle handshake.
            state_d = IDLE;
            f_load  = 1'b1;
            s_load  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if ((num_filters != '0) && (num_steps != '0)) begin
                            num_filters_d = num_filters;
                            num_steps_d   = num_steps;
                            f_load        = 1'b1;
                            s_load        = 1'b1;
                            state_d       = LOAD_BIAS;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                LOAD_BIAS: state_d = ACCUM;
                ACCUM: begin
                    if (step_valid) begin
                        if (s_tc) begin
                            s_load  = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            s_inc = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (f_tc) begin
                            state_d = DONE;
                        end else begin
                            f_inc   = 1'b1;
                            state_d = LOAD_BIAS;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            num_filters_q <= '0;
            num_steps_q   <= '0;
        end else begin
            state_q       <= state_d;
            num_filters_q <= num_filters_d;
            num_steps_q   <= num_steps_d;
        end
    end

    // All outputs decode the registered state; only buf_enable also follows
    // step_valid so an adder result is captured in the cycle it is presented.
    assign step_req     = (state_q == ACCUM);
    assign buf_w_enable = (state_q == LOAD_BIAS);
    assign buf_enable   = (state_q == ACCUM) && step_valid;
    assign out_valid    = (state_q == DRAIN);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign bias_idx     = filter_idx;
    assign state_dbg    = state_q;

`ifdef APE_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        perf_clr, perf_stall;

    assign perf_clr   = (state_q == IDLE) && start && !abort;
    assign perf_stall = ((state_q == ACCUM) && !step_valid) ||
                        ((state_q == DRAIN) && !out_ready);

    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (perf_stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/ape_buffer_scheduler.md
Name: ape_buffer_scheduler

Overview:
- Controller that sequences one APE output-buffer tile through its compute phases.
- Per filter, the phases are: bias preload, then `num_steps` accumulate steps, then drain of the finished tile to the writeback stage.
- Drives the buffer's bias-load strobe (`w_enable`) and accumulate strobe (`enable`), and supplies the bias index to the bias memory.
- Sits between the top-level layer controller (start/done) and the APE datapath (adders + buffer).

Parameters:
- FILTER_CNT_W, 8: width of filter count and filter index.
- STEP_CNT_W, 12: width of accumulate-step count and step index (kernel_h*kernel_w*in_ch).

Ports:
- clock, input, 1: single clock; all state updates on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a layer; sampled only in IDLE.
- abort, input, 1: synchronous abort; return to IDLE, no done pulse.
- num_filters, input, FILTER_CNT_W: filters in the layer; latched on accepted start.
- num_steps, input, STEP_CNT_W: accumulate steps per filter; latched on accepted start.
- step_valid, input, 1: adder outputs valid this cycle.
- step_req, output, 1: scheduler is ready to consume an adder result.
- buf_w_enable, output, 1: bias load strobe to the buffer.
- buf_enable, output, 1: accumulate strobe to the buffer.
- bias_idx, output, FILTER_CNT_W: bias memory address; equals filter_idx.
- filter_idx, output, FILTER_CNT_W: current filter.
- step_idx, output, STEP_CNT_W: current accumulate step.
- out_valid, output, 1: buffer tile complete and held stable.
- out_ready, input, 1: writeback accepts the tile.
- busy, output, 1: state != IDLE.
- done, output, 1: one-cycle pulse when the layer completes.
- perf_stall_cycles, output, 32: stall counter (see Optional Feature).

Behaviour:
- FSM states: IDLE, LOAD_BIAS, ACCUM, DRAIN, DONE. State and counters are registered.
- Reset (reset_n low, asynchronous): state=IDLE; filter_idx=0, step_idx=0; latched counts=0; perf counter=0.
  - All strobes, out_valid, done and busy read 0.
  - Reset mid-operation abandons the tile; the buffer contents are don't-care.
- IDLE:
  - start=1 with both counts nonzero: latch counts, clear indices, go to LOAD_BIAS.
  - start=1 with either count zero: go to DONE directly; no strobes are issued.
- LOAD_BIAS: exactly one cycle. buf_w_enable=1, bias_idx=filter_idx. Next state ACCUM.
- ACCUM:
  - step_req=1.
  - buf_enable = step_valid, combinational in the same cycle.
  - On step_valid: step_idx increments. If step_idx==num_steps_q-1, go to DRAIN and clear step_idx.
  - step_valid low: hold state (stall).
- DRAIN:
  - out_valid=1, held until out_ready. Buffer strobes stay 0, so the tile is stable.
  - On out_valid&out_ready: if filter_idx==num_filters_q-1, go to DONE; else filter_idx++ and go to LOAD_BIAS.
- DONE: done=1 for one cycle, then IDLE. Back-to-back start is accepted the cycle after DONE.
- Invariants:
  - buf_w_enable and buf_enable are never both 1.
  - No strobe fires outside LOAD_BIAS or ACCUM.
- Timing: bias load happens 1 cycle after start is accepted. Minimum cycles per filter = 1 + num_steps + 1.
- start while busy is ignored.
- abort has priority over every transition, including a same-cycle handshake.
  - Next state is IDLE; counters are cleared.
  - No done pulse is issued.
- Counters never wrap: terminal compares use the latched count minus 1.

Optional Feature:
- Macro: APE_SCHED_PERF_EN.
- Defined: perf_stall_cycles counts cycles in (ACCUM & !step_valid) | (DRAIN & !out_ready).
  - Saturates at 2^32-1.
  - Cleared on accepted start and on reset.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package ape_sched_pkg holds:
  - the state enum type (IDLE, LOAD_BIAS, ACCUM, DRAIN, DONE);
  - the default widths FILTER_CNT_W and STEP_CNT_W.
- Global datapath sizes remain in sys_defs.svh.
- One natural sub-module: ape_sched_counter, a loadable up-counter with terminal-count flag. It is instantiated for filter_idx and step_idx.

Test Plan:
- num_filters=2, num_steps=3, step_valid=1 constant, out_ready=1:
  - buf_w_enable pulses at cycles 1 and 6; buf_enable high at cycles 2-4 and 7-9;
  - bias_idx reads 0 then 1; done pulses at cycle 11.
- num_filters=1, num_steps=4, step_valid toggling 1,0,1,0,...: exactly 4 buf_enable pulses; step_idx advances only on valid; DRAIN is entered after the 4th valid.
- Hold out_ready=0 for 5 cycles in DRAIN:
  - out_valid stays 1 and no strobes fire;
  - with APE_SCHED_PERF_EN, perf_stall_cycles=5.
- start with num_steps=0: done pulses 1 cycle later; buf_w_enable and buf_enable stay 0 throughout.
- Corner cases in ACCUM:
  - abort at step 2: next cycle state is IDLE, busy=0, no done pulse.
  - reset_n low for 1 cycle mid-ACCUM: outputs clear asynchronously.
- Assert start while busy: no effect on the indices or the latched counts.
